// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter: round-robin arbiter sharing one multdiv unit between two requesters,
// with a WAIT-cycle timeout that abandons operations the unit never completes.
module multdiv_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req0_div,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_div,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_data,
    output logic        resp_exception,
    output logic        resp_timeout,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [5:0] TMO = 6'(TIMEOUT);
    state_t     state, state_nxt;
    logic       last_grant, grant_id, op_div, gnt0, gnt1, done, expired;
    logic [5:0] cnt;
    // last_grant resets to 1 so port 0 wins the first tie
    assign gnt0 = state == IDLE && req0_valid && (!req1_valid || last_grant);
    assign gnt1 = state == IDLE && req1_valid && (!req0_valid || !last_grant);
    assign done = state == WAIT && md_ready;
    assign expired = state == WAIT && !md_ready && cnt == TMO;
    always_comb begin
        state_nxt     = state;
        req0_ready    = gnt0;
        req1_ready    = gnt1;
        md_start_mult = state == ISSUE && !op_div;
        md_start_div  = state == ISSUE && op_div;
        resp0_valid   = state == RESP && !grant_id;
        resp1_valid   = state == RESP && grant_id;
        case (state)
            IDLE:    state_nxt = (gnt0 || gnt1) ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (done || expired) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant_id       <= 1'b0;
            op_div         <= 1'b0;
            cnt            <= '0;
            md_a           <= '0;
            md_b           <= '0;
            resp_data      <= '0;
            resp_exception <= 1'b0;
            resp_timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + 6'd1 : 6'd0;
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                grant_id   <= gnt1;
                op_div     <= gnt1 ? req1_div : req0_div;
                md_a       <= gnt1 ? req1_a : req0_a;
                md_b       <= gnt1 ? req1_b : req0_b;
            end
            if (done) begin
                resp_data      <= md_result;
                resp_exception <= md_exception;
                resp_timeout   <= 1'b0;
            end else if (expired) begin
                resp_data      <= '0;
                resp_exception <= 1'b1;
                resp_timeout   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_arbiter.sv
// tb_multdiv_arbiter: directed and randomized transactions checked against a
// transaction-level model of grant order, operation result and response timing.
module tb_multdiv_arbiter;
    localparam int TO = 40;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        req0_valid = 0, req0_div = 0, req1_valid = 0, req1_div = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp_data, md_a, md_b;
    logic        resp_exception, resp_timeout, md_start_mult, md_start_div;
    logic [31:0] md_result = 0;
    logic        md_exception = 0, md_ready = 0;
    int n_cmp = 0, n_err = 0, last_g = 1;

    multdiv_arbiter #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_div(req0_div), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_div(req1_div), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
        .resp_exception(resp_exception), .resp_timeout(resp_timeout),
        .md_start_mult(md_start_mult), .md_start_div(md_start_div), .md_a(md_a), .md_b(md_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk1({tag, "_rdy"}, req0_ready | req1_ready, 1'b0);
        chk1({tag, "_rsp"}, resp0_valid | resp1_valid, 1'b0);
        chk1({tag, "_start"}, md_start_mult | md_start_div, 1'b0);
        chk1({tag, "_flags"}, resp_exception | resp_timeout, 1'b0);
        chk({tag, "_data"}, resp_data, 32'd0);
        chk({tag, "_md_a"}, md_a, 32'd0);
        chk({tag, "_md_b"}, md_b, 32'd0);
    endtask

    // dly: WAIT cycle (1-based) on which the unit reports done; beyond TO+1 means it never does
    task automatic op(input logic v0, input logic v1, input logic d0, input logic d1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input int dly, input logic stray);
        int g, r;
        logic dv, exc, tmo;
        logic [31:0] a, b, res;
        g = (v0 && v1) ? 1 - last_g : (v0 ? 0 : 1);
        last_g = g;
        dv = (g == 1) ? d1 : d0;
        a = (g == 1) ? a1 : a0;
        b = (g == 1) ? b1 : b0;
        res = dv ? ((b == 0) ? 32'hFFFF_FFFF : a / b) : a * b;
        exc = dv && (b == 0);
        tmo = (dly < 1) || (dly > TO + 1);
        r = tmo ? TO + 1 : dly;
        {req0_valid, req0_div, req0_a, req0_b} = {v0, d0, a0, b0};
        {req1_valid, req1_div, req1_a, req1_b} = {v1, d1, a1, b1};
        #1;
        chk1("ready0", req0_ready, g == 0);
        chk1("ready1", req1_ready, g == 1);
        step();
        md_ready = stray;
        md_result = $urandom;
        #1;
        chk1("start_mult", md_start_mult, !dv);
        chk1("start_div", md_start_div, dv);
        chk1("issue_rdy", req0_ready | req1_ready, 1'b0);
        chk("issue_md_a", md_a, a);
        chk("issue_md_b", md_b, b);
        req0_valid = 0;
        req1_valid = 0;
        for (int k = 1; k <= r; k++) begin
            step();
            md_ready = (k == dly);
            md_result = md_ready ? res : $urandom;
            md_exception = md_ready ? exc : 1'($urandom);
            chk1("wait_rsp", resp0_valid | resp1_valid, 1'b0);
            chk1("wait_start", md_start_mult | md_start_div, 1'b0);
        end
        step();
        md_ready = 0;
        chk1("resp0", resp0_valid, g == 0);
        chk1("resp1", resp1_valid, g == 1);
        chk("resp_data", resp_data, tmo ? 32'd0 : res);
        chk1("resp_exc", resp_exception, tmo ? 1'b1 : exc);
        chk1("resp_tmo", resp_timeout, tmo);
        chk("resp_md_a", md_a, a);
        step();
        chk1("post_rsp", resp0_valid | resp1_valid, 1'b0);
        chk("hold_data", resp_data, tmo ? 32'd0 : res);
        chk1("hold_tmo", resp_timeout, tmo);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        all_zero("reset");
        reset_n = 1;
        step();
        // three back-to-back ties alternate 0,1,0
        op(1, 1, 0, 0, 32'd3, 32'd4, 32'd5, 32'd6, 3, 0);
        op(1, 1, 0, 1, 32'd3, 32'd4, 32'd50, 32'd6, 2, 0);
        op(1, 1, 1, 0, 32'd30, 32'd4, 32'd5, 32'd6, 1, 0);
        op(1, 0, 0, 0, 32'd7, 32'd6, 32'd0, 32'd0, 16, 0);
        op(0, 1, 0, 1, 32'd0, 32'd0, 32'd5, 32'd0, 4, 0);
        op(1, 0, 0, 0, 32'd9, 32'd9, 32'd0, 32'd0, 0, 0);
        op(0, 1, 1, 1, 32'd0, 32'd0, 32'd100, 32'd7, TO + 1, 1);
        op(1, 0, 0, 0, 32'd11, 32'd13, 32'd0, 32'd0, TO + 2, 1);
        // reset in the middle of WAIT abandons the operation silently
        {req1_valid, req1_div, req1_a, req1_b} = {1'b1, 1'b0, 32'd8, 32'd8};
        step();
        req1_valid = 0;
        repeat (3) step();
        reset_n = 0;
        #1;
        all_zero("mid_reset");
        step();
        reset_n = 1;
        last_g = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("no_rsp_after_reset", resp0_valid | resp1_valid, 1'b0);
            chk1("no_start_after_reset", md_start_mult | md_start_div, 1'b0);
        end
        op(1, 1, 0, 0, 32'd12, 32'd12, 32'd2, 32'd2, 5, 0);
        for (int i = 0; i < 24; i++) begin
            logic v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1;
            op(v0, v1, 1'($urandom), 1'($urandom), $urandom,
               ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom, $urandom,
               ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom,
               $urandom_range(TO + 3, 1), 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
